// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter (parallel word in, MSB-first serial bit stream out).
// Latency: first bit on `a` the cycle after the accepting edge; one bit per clock after that.
// Backpressure: din_ready is low while bits remain; it is high on the a_last cycle so words can run back-to-back.
//
// Ports:
//   clk, rst (async active-low)
//   din[WIDTH-1:0], len[LW-1:0], din_valid -> din_ready   : word input handshake
//   a, a_valid, a_last, busy                              : registered serial output + qualifiers
module seq_gen #(
  parameter int       WIDTH      = 8,
  parameter int       LW         = $clog2(WIDTH+1),
  parameter bit       IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [LW-1:0]    len,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             a,
  output logic             a_valid,
  output logic             a_last,
  output logic             busy
);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [LW-1:0]    r_cnt;
  logic             r_a;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [LW-1:0]    w_cnt_nxt;
  logic             w_a_nxt;
  logic             w_accept;
  logic             w_cnt_zero;
  logic [LW-1:0]    w_n_eff;

  // a_valid is the SEND state itself, so it stays a registered output.
  assign a_valid    = (r_state == S_SEND);
  assign a          = r_a;
  assign w_cnt_zero = (r_cnt == '0);
  assign din_ready  = ~a_valid | w_cnt_zero;
  assign a_last     = a_valid & w_cnt_zero;
  assign busy       = a_valid;
  assign w_accept   = din_valid & din_ready;

  // Zero or an out-of-range length both mean "send the whole word".
  assign w_n_eff = ((len == '0) || (len > LW'(WIDTH))) ? LW'(WIDTH) : len;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    if (w_accept) begin
      // Also covers the a_last cycle: the new word loads with no idle bubble.
      w_state_nxt = S_SEND;
      w_a_nxt     = din[WIDTH-1];
      w_shreg_nxt = din << 1;
      w_cnt_nxt   = w_n_eff - LW'(1);
    end else if (r_state == S_SEND) begin
      if (!w_cnt_zero) begin
        w_a_nxt     = r_shreg[WIDTH-1];
        w_shreg_nxt = r_shreg << 1;
        w_cnt_nxt   = r_cnt - LW'(1);
      end else begin
        w_state_nxt = S_IDLE;
        w_a_nxt     = IDLE_LEVEL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_a     <= IDLE_LEVEL;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
    end
  end

endmodule
